// File: rtl/rf_access_ctrl.sv
// Two-requester round-robin access controller in front of a UID-tagged register file.
// Sequences lookup, owner check, optional commit and response; counts refused accesses.
module rf_access_ctrl #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 12,
    parameter int unsigned UID_W  = 12,
    parameter int unsigned RD_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req0_i,
    input  logic              req1_i,
    input  logic              we0_i,
    input  logic              we1_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wd0_i,
    input  logic [DATA_W-1:0] wd1_i,
    input  logic [UID_W-1:0]  uid0_i,
    input  logic [UID_W-1:0]  uid1_i,
    output logic              ack0_o,
    output logic              ack1_o,
    output logic              deny_o,
    output logic [RD_W-1:0]   rdata_o,
    output logic              busy_o,
    output logic [7:0]        viol_cnt_o,
    output logic [ADDR_W-1:0] rf_adr1_o,
    output logic [ADDR_W-1:0] rf_wa_o,
    output logic [DATA_W-1:0] rf_wd_o,
    output logic [UID_W-1:0]  u_id_o,
    output logic              rf_en_o,
    input  logic [RD_W-1:0]   rf_rs1_i,
    input  logic [UID_W-1:0]  rf_uid_out_i
);

    typedef enum logic [2:0] {StIdle, StLookup, StCheck, StCommit, StResp} state_e;

    state_e            state_q, state_d;
    logic              last_q, last_d;
    logic              gnt_q, gnt_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wd_q, wd_d;
    logic [UID_W-1:0]  uid_q, uid_d;
    logic [RD_W-1:0]   rs1_q, rs1_d;
    logic [UID_W-1:0]  owner_q, owner_d;
    logic              ack0_q, ack0_d, ack1_q, ack1_d, deny_q, deny_d;
    logic [RD_W-1:0]   rdata_q, rdata_d;
    logic              busy_q, busy_d;
    logic [7:0]        viol_q, viol_d;
    logic [ADDR_W-1:0] rf_adr1_q, rf_adr1_d, rf_wa_q, rf_wa_d;
    logic [DATA_W-1:0] rf_wd_q, rf_wd_d;
    logic [UID_W-1:0]  u_id_q, u_id_d;
    logic              rf_en_q, rf_en_d;
    logic              allow, win;

    // UID 0 is reserved and never allowed, even on an unowned register.
    assign allow = (uid_q != '0) && ((owner_q == '0) || (owner_q == uid_q));

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        gnt_d     = gnt_q;
        we_d      = we_q;
        wd_d      = wd_q;
        uid_d     = uid_q;
        rs1_d     = rs1_q;
        owner_d   = owner_q;
        ack0_d    = 1'b0;
        ack1_d    = 1'b0;
        deny_d    = 1'b0;
        rdata_d   = '0;
        viol_d    = viol_q;
        rf_adr1_d = rf_adr1_q;
        rf_wa_d   = rf_wa_q;
        rf_wd_d   = rf_wd_q;
        u_id_d    = u_id_q;
        rf_en_d   = 1'b0;
        win       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req0_i || req1_i) begin
                    win       = (req0_i && req1_i) ? ~last_q : req1_i;
                    last_d    = win;
                    gnt_d     = win;
                    we_d      = win ? we1_i : we0_i;
                    rf_adr1_d = win ? addr1_i : addr0_i;
                    wd_d      = win ? wd1_i : wd0_i;
                    uid_d     = win ? uid1_i : uid0_i;
                    state_d   = StLookup;
                end
            end
            StLookup: begin
                rs1_d   = rf_rs1_i;
                owner_d = rf_uid_out_i;
                state_d = StCheck;
            end
            StCheck: begin
                if (allow && we_q) begin
                    rf_en_d = 1'b1;
                    rf_wa_d = rf_adr1_q;
                    rf_wd_d = wd_q;
                    u_id_d  = uid_q;
                    state_d = StCommit;
                end else begin
                    ack0_d  = ~gnt_q;
                    ack1_d  = gnt_q;
                    deny_d  = ~allow;
                    rdata_d = (allow && !we_q) ? rs1_q : '0;
                    if (!allow && (viol_q != 8'hFF)) viol_d = viol_q + 8'd1;
                    state_d = StResp;
                end
            end
            StCommit: begin
                ack0_d  = ~gnt_q;
                ack1_d  = gnt_q;
                state_d = StResp;
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            last_q    <= 1'b1;
            gnt_q     <= 1'b0;
            we_q      <= 1'b0;
            wd_q      <= '0;
            uid_q     <= '0;
            rs1_q     <= '0;
            owner_q   <= '0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            deny_q    <= 1'b0;
            rdata_q   <= '0;
            busy_q    <= 1'b0;
            viol_q    <= '0;
            rf_adr1_q <= '0;
            rf_wa_q   <= '0;
            rf_wd_q   <= '0;
            u_id_q    <= '0;
            rf_en_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            gnt_q     <= gnt_d;
            we_q      <= we_d;
            wd_q      <= wd_d;
            uid_q     <= uid_d;
            rs1_q     <= rs1_d;
            owner_q   <= owner_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            deny_q    <= deny_d;
            rdata_q   <= rdata_d;
            busy_q    <= busy_d;
            viol_q    <= viol_d;
            rf_adr1_q <= rf_adr1_d;
            rf_wa_q   <= rf_wa_d;
            rf_wd_q   <= rf_wd_d;
            u_id_q    <= u_id_d;
            rf_en_q   <= rf_en_d;
        end
    end

    assign ack0_o     = ack0_q;
    assign ack1_o     = ack1_q;
    assign deny_o     = deny_q;
    assign rdata_o    = rdata_q;
    assign busy_o     = busy_q;
    assign viol_cnt_o = viol_q;
    assign rf_adr1_o  = rf_adr1_q;
    assign rf_wa_o    = rf_wa_q;
    assign rf_wd_o    = rf_wd_q;
    assign u_id_o     = u_id_q;
    assign rf_en_o    = rf_en_q;

endmodule

// File: tb/tb_rf_access_ctrl.sv
// Bench for rf_access_ctrl: behavioural register file, table vectors, random traffic
// against an access-rule model, arbitration, saturation and mid-transaction reset.
module tb_rf_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1, we0, we1;
    logic [3:0]  addr0, addr1;
    logic [11:0] wd0, wd1, uid0, uid1;
    logic        ack0, ack1, deny, busy, rf_en;
    logic [15:0] rdata, rf_rs1;
    logic [7:0]  viol;
    logic [3:0]  rf_adr1, rf_wa;
    logic [11:0] rf_wd, u_id, rf_uid_out;

    always #5 clk = ~clk;

    rf_access_ctrl dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
        .addr0_i(addr0), .addr1_i(addr1), .wd0_i(wd0), .wd1_i(wd1),
        .uid0_i(uid0), .uid1_i(uid1),
        .ack0_o(ack0), .ack1_o(ack1), .deny_o(deny), .rdata_o(rdata), .busy_o(busy),
        .viol_cnt_o(viol), .rf_adr1_o(rf_adr1), .rf_wa_o(rf_wa), .rf_wd_o(rf_wd),
        .u_id_o(u_id), .rf_en_o(rf_en), .rf_rs1_i(rf_rs1), .rf_uid_out_i(rf_uid_out)
    );

    // Behavioural reg_file the DUT drives; cleared only by rf_clr, never by rst_n.
    logic        rf_clr;
    logic [11:0] rf_mem [16];
    logic [11:0] rf_own [16];
    assign rf_rs1     = {4'h0, rf_mem[rf_adr1]};
    assign rf_uid_out = rf_own[rf_adr1];
    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 16; i++) begin
                rf_mem[i] <= '0;
                rf_own[i] <= '0;
            end
        end else if (rf_en) begin
            rf_mem[rf_wa] <= rf_wd;
            rf_own[rf_wa] <= u_id;
        end
    end

    // Reference model: register contents/owners, violation count, last-served requester.
    logic [11:0] md [16];
    logic [11:0] mo [16];
    int          mviol;
    int          mlast;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic scramble();
        we0 = 1'($urandom); we1 = 1'($urandom);
        addr0 = 4'($urandom); addr1 = 4'($urandom);
        wd0 = 12'($urandom); wd1 = 12'($urandom);
        uid0 = 12'($urandom); uid1 = 12'($urandom);
    endtask

    task automatic do_txn(input int r, input bit we, input logic [3:0] a,
                          input logic [11:0] wd, input logic [11:0] uid,
                          output bit o_deny, output logic [15:0] o_rd, output int o_lat);
        bit          allow;
        logic [15:0] exp_rd;
        int          en_cnt;
        int          who;
        allow  = (uid != 0) && (mo[a] == 0 || mo[a] == uid);
        exp_rd = (allow && !we) ? {4'h0, md[a]} : 16'h0;
        en_cnt = 0;
        o_lat  = 0;
        who    = -1;
        @(negedge clk);
        if (r == 0) begin req0 = 1'b1; we0 = we; addr0 = a; wd0 = wd; uid0 = uid; end
        else        begin req1 = 1'b1; we1 = we; addr1 = a; wd1 = wd; uid1 = uid; end
        @(posedge clk);
        #1;
        req0 = 1'b0; req1 = 1'b0;
        scramble();
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (rf_en) en_cnt++;
            if (k == 1) chk("busy_after_grant", busy, 1);
            if (ack0 || ack1) begin
                o_lat = k;
                who   = ack1 ? 1 : 0;
                break;
            end
        end
        o_deny = deny;
        o_rd   = rdata;
        if (allow && we) begin
            md[a] = wd;
            mo[a] = uid;
        end
        if (!allow && mviol < 255) mviol++;
        mlast = r;
        chk("ack_seen_within_bound", (o_lat != 0), 1);
        chk("ack_id", who, r);
        chk("ack_both", (ack0 && ack1), 0);
        chk("latency", o_lat, (allow && we) ? 4 : 3);
        chk("deny", deny, !allow);
        chk("rdata", rdata, exp_rd);
        chk("viol_cnt", viol, mviol);
        chk("rf_en_cycles", en_cnt, (allow && we) ? 1 : 0);
        chk("rf_data", rf_mem[a], md[a]);
        chk("rf_owner", rf_own[a], mo[a]);
    endtask

    // Both requesters held high with reads of reg 3; grants must alternate.
    task automatic arb_run(input int n);
        int exp_who;
        int got;
        exp_who = 1 - mlast;
        got     = 0;
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'd3; wd0 = '0; uid0 = 12'h011;
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'd3; wd1 = '0; uid1 = 12'h011;
        for (int k = 0; k < n * 6 + 8; k++) begin
            @(negedge clk);
            if (rf_en) chk("arb_no_rf_en", rf_en, 0);
            if (ack0 || ack1) begin
                chk("arb_single_ack", (ack0 && ack1), 0);
                chk("arb_order", ack1 ? 1 : 0, exp_who);
                chk("arb_rdata", rdata, {4'h0, md[3]});
                mlast   = exp_who;
                exp_who = 1 - exp_who;
                got++;
                if (got == n) begin
                    req0 = 1'b0; req1 = 1'b0;
                    break;
                end
            end
        end
        chk("arb_ack_count", got, n);
    endtask

    typedef struct {
        int          r;
        bit          we;
        logic [3:0]  a;
        logic [11:0] wd;
        logic [11:0] uid;
        bit          deny;
        logic [15:0] rd;
        int          lat;
    } vec_t;

    vec_t        tbl [8];
    bit          o_deny;
    logic [15:0] o_rd;
    int          o_lat;
    logic [11:0] uids [4];
    bit          saw_bad;

    initial begin
        tbl[0] = '{0, 1'b1, 4'd3, 12'hABC, 12'h011, 1'b0, 16'h0000, 4};
        tbl[1] = '{1, 1'b0, 4'd3, 12'h000, 12'h022, 1'b1, 16'h0000, 3};
        tbl[2] = '{0, 1'b0, 4'd3, 12'h000, 12'h011, 1'b0, 16'h0ABC, 3};
        tbl[3] = '{1, 1'b1, 4'd7, 12'h555, 12'h022, 1'b0, 16'h0000, 4};
        tbl[4] = '{0, 1'b1, 4'd7, 12'h111, 12'h011, 1'b1, 16'h0000, 3};
        tbl[5] = '{1, 1'b0, 4'd7, 12'h000, 12'h022, 1'b0, 16'h0555, 3};
        tbl[6] = '{0, 1'b1, 4'd5, 12'h123, 12'h000, 1'b1, 16'h0000, 3};
        tbl[7] = '{1, 1'b0, 4'd9, 12'h000, 12'h000, 1'b1, 16'h0000, 3};
        uids[0] = 12'h000; uids[1] = 12'h011; uids[2] = 12'h022; uids[3] = 12'h033;
        for (int i = 0; i < 16; i++) begin md[i] = '0; mo[i] = '0; end
        mviol = 0;
        mlast = 1;
        req0 = 1'b0; req1 = 1'b0;
        scramble();
        rst_n  = 1'b0;
        rf_clr = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rf_clr = 1'b0;
        chk("rst_ack", {ack0, ack1}, 0);
        chk("rst_deny_en_busy", {deny, rf_en, busy}, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_viol", viol, 0);
        chk("rst_addrs", {rf_adr1, rf_wa, rf_wd, u_id}, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            do_txn(tbl[i].r, tbl[i].we, tbl[i].a, tbl[i].wd, tbl[i].uid, o_deny, o_rd, o_lat);
            chk("tbl_deny", o_deny, tbl[i].deny);
            chk("tbl_rdata", o_rd, tbl[i].rd);
            chk("tbl_latency", o_lat, tbl[i].lat);
        end

        arb_run(4);

        for (int i = 0; i < 150; i++) begin
            do_txn(int'($urandom_range(0, 1)), 1'($urandom), 4'($urandom),
                   12'($urandom), uids[$urandom_range(0, 3)], o_deny, o_rd, o_lat);
        end

        for (int i = 0; i < 260; i++) begin
            do_txn(i % 2, 1'($urandom), 4'($urandom), 12'($urandom), 12'h000,
                   o_deny, o_rd, o_lat);
        end
        chk("viol_saturated", viol, 255);

        // Reset while an allowed write is in CHECK: nothing may be written or acked.
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; addr0 = 4'd3; wd0 = 12'h777; uid0 = 12'h011;
        @(posedge clk);
        #1 req0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ack", {ack0, ack1}, 0);
        chk("mid_rst_deny_en_busy", {deny, rf_en, busy}, 0);
        chk("mid_rst_rdata_viol", {rdata, viol}, 0);
        chk("mid_rst_addrs", {rf_adr1, rf_wa, rf_wd, u_id}, 0);
        saw_bad = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (rf_en || ack0 || ack1) saw_bad = 1'b1;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (rf_en || ack0 || ack1) saw_bad = 1'b1;
        end
        chk("mid_rst_no_activity", saw_bad, 0);
        chk("mid_rst_no_write", rf_mem[3], md[3]);
        mviol = 0;
        mlast = 1;
        arb_run(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
